array_mult4_mac: RTL and testbench

Sequential multiply-accumulate stage that consumes the combinational 4x4 array multiplier (`Array_Mult4`). It accepts a stream of 4-bit operand pairs over a valid/ready handshake and registers each pair. It feeds the registered pair to `Array_Mult4` and sums the 8-bit products into an accumulator. After `N_TERMS` pairs, or earlier on a pair flagged `in_last`, it presents the dot-product result on a valid/ready output port.

---
 rtl/array_mult4_mac_pkg.sv | 17 +
 rtl/array_mult4_mac_array_mult4.sv | 28 ++
 rtl/array_mult4_mac.sv | 131 +++++++++++++
 tb/tb_array_mult4_mac.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/array_mult4_mac_pkg.sv
// -----------------------------------------------------------------------------
// array_mult4_mac_pkg
//   Shared definitions for the array_mult4_mac multiply-accumulate stage:
//   operand/product widths and the control FSM state encoding.
// -----------------------------------------------------------------------------
package array_mult4_mac_pkg;

  localparam int OP_W   = 4;  // operand width (x, y)
  localparam int PROD_W = 8;  // full product width of a 4x4 multiply

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,  // accepting operand pairs
    ST_DRAIN = 2'd1,  // last pair registered, final add pending
    ST_DONE  = 2'd2   // result presented on the output port
  } state_e;

endpackage : array_mult4_mac_pkg

// File: rtl/array_mult4_mac_array_mult4.sv
// -----------------------------------------------------------------------------
// Array_Mult4
//   Combinational 4x4 unsigned array multiplier. Each row is the multiplicand
//   gated by one multiplier bit, shifted to its weight and summed down the
//   array.
//   Ports:
//     a  in  OP_W    multiplicand, unsigned
//     b  in  OP_W    multiplier, unsigned
//     p  out PROD_W  product a*b
// -----------------------------------------------------------------------------
module Array_Mult4
  import array_mult4_mac_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  always_comb begin
    // NOTE: blocking assignments here are intentional: each loop iteration
    // builds on the partial sum of the previous row within the same evaluation.
    p = '0;
    for (int i = 0; i < OP_W; i++) begin
      p = p + (PROD_W'(a & {OP_W{b[i]}}) << i);
    end
  end

endmodule : Array_Mult4

// File: rtl/array_mult4_mac.sv
// -----------------------------------------------------------------------------
// array_mult4_mac
//   Sequential multiply-accumulate stage. Operand pairs arrive over a
//   valid/ready handshake, are registered, multiplied by Array_Mult4 and the
//   products summed into an accumulator. After N_TERMS pairs (or earlier on a
//   pair flagged in_last) the dot product is offered on a valid/ready output.
//   Parameters:
//     N_TERMS  max pairs per dot product (1..16)
//     ACC_W    accumulator width, at least 8 + clog2(N_TERMS)
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     in_valid   in   operand pair valid
//     in_ready   out  block accepts a pair this cycle (state decode)
//     x, y       in   4-bit unsigned operands
//     in_last    in   accepted pair ends the dot product early
//     out_valid  out  acc holds a finished result (state decode)
//     out_ready  in   consumer takes the result
//     acc        out  accumulated sum
// -----------------------------------------------------------------------------
module array_mult4_mac
  import array_mult4_mac_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  x,
  input  logic [OP_W-1:0]  y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc
);

  localparam int CNT_W = $clog2(N_TERMS + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   x_q, x_d;
  logic [OP_W-1:0]   y_q, y_d;
  logic              v_q, v_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PROD_W-1:0] prod;
  logic              accept;
  logic              last_term;

  Array_Mult4 u_mult (
    .a (x_q),
    .b (y_q),
    .p (prod)
  );

  // Handshake outputs decode the state only, so there is no combinational
  // path from in_valid/out_ready back to them.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign acc       = acc_q;

  assign accept    = in_valid && in_ready;
  // cnt_q never exceeds N_TERMS-1 while in ACC, so the increment cannot wrap.
  assign last_term = in_last || ((cnt_q + CNT_W'(1)) == CNT_W'(N_TERMS));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case/if tree can leave a signal unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    v_d     = 1'b0;
    acc_d   = acc_q;

    if (accept) begin
      x_d   = x;
      y_d   = y;
      v_d   = 1'b1;
      cnt_d = cnt_q + CNT_W'(1);
    end

    // The product of a pair registered on the previous edge is added now;
    // this is also how the final add lands on the DRAIN -> DONE edge.
    if (v_q) begin
      acc_d = acc_q + ACC_W'(prod);
    end

    unique case (state_q)
      ST_ACC: begin
        if (accept && last_term) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // v_q is always 0 here (no accepts in DRAIN), so clearing is safe.
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      v_q     <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      v_q     <= v_d;
      acc_q   <= acc_d;
    end
  end

endmodule : array_mult4_mac

// File: tb/tb_array_mult4_mac.sv
// -----------------------------------------------------------------------------
// tb_array_mult4_mac
//   Self-checking bench for array_mult4_mac: a table of dot products with
//   hand-computed results feeds a scoreboard queue, plus hand-written
//   sequences for timing, backpressure, bubbles, reset and a 16-term instance.
// -----------------------------------------------------------------------------
module tb_array_mult4_mac;

  logic        clk = 1'b0;
  logic        rst;

  // Default-parameter instance
  logic        in_valid, in_ready, in_last, out_valid, out_ready;
  logic [3:0]  x, y;
  logic [11:0] acc;

  // N_TERMS=16 instance
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
  logic [3:0]  b_x, b_y;
  logic [11:0] b_acc;

  int checks = 0;
  int errors = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  array_mult4_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc)
  );

  array_mult4_mac #(.N_TERMS(16), .ACC_W(12)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .x         (b_x),
    .y         (b_y),
    .in_last   (b_in_last),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .acc       (b_acc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples mid-low-phase, after negedge-driven inputs settle.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'(acc), 32'hFFFF_FFFF);
      end else begin
        check("dp_result", 32'(acc), 32'(sb_q.pop_front()));
      end
    end
  end

  // Called at a negedge; returns at the following negedge with in_valid low.
  task automatic send_pair(input logic [3:0] px, input logic [3:0] py, input logic plast);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x        = px;
    y        = py;
    in_last  = plast;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      check("result_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    int          n;
    logic [15:0] xv;       // nibble i = x of pair i
    logic [15:0] yv;       // nibble i = y of pair i
    logic        use_last; // flag in_last on the final pair
    int          exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{n: 4, xv: {4'd1, 4'd15, 4'd3, 4'd4}, yv: {4'd0, 4'd15, 4'd5, 4'd4}, use_last: 1'b0, exp: 256};
    tbl[1] = '{n: 2, xv: {8'h00, 4'd7, 4'd2},       yv: {8'h00, 4'd7, 4'd3},       use_last: 1'b1, exp: 55};
    tbl[2] = '{n: 4, xv: 16'h1111,                  yv: 16'h1111,                  use_last: 1'b0, exp: 4};
    tbl[3] = '{n: 4, xv: 16'h0000,                  yv: 16'h0000,                  use_last: 1'b0, exp: 0};
    tbl[4] = '{n: 4, xv: {4'd2, 4'd8, 4'd1, 4'd15}, yv: {4'd2, 4'd8, 4'd15, 4'd1}, use_last: 1'b0, exp: 98};
    tbl[5] = '{n: 1, xv: 16'h0009,                  yv: 16'h0009,                  use_last: 1'b1, exp: 81};
    tbl[6] = '{n: 4, xv: 16'h2222,                  yv: 16'h2222,                  use_last: 1'b1, exp: 16};

    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; x = '0; y = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_x = '0; b_y = '0; b_out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_acc",       32'(acc),       32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven dot products
    for (int t = 0; t < 7; t++) begin
      sb_q.push_back(tbl[t].exp);
      for (int i = 0; i < tbl[t].n; i++) begin
        send_pair(tbl[t].xv[4*i +: 4], tbl[t].yv[4*i +: 4],
                  tbl[t].use_last && (i == tbl[t].n - 1));
      end
      wait_drain();
    end

    // Max value and handshake timing: DRAIN, DONE, then back to ACC
    sb_q.push_back(900);
    for (int i = 0; i < 4; i++) send_pair(4'd15, 4'd15, 1'b0);
    check("max_drain_in_ready",  32'(in_ready),  32'd0);
    check("max_drain_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("max_done_in_ready",   32'(in_ready),  32'd0);
    check("max_done_out_valid",  32'(out_valid), 32'd1);
    check("max_done_acc",        32'(acc),       32'd900);
    @(negedge clk);
    check("max_after_in_ready",  32'(in_ready),  32'd1);
    check("max_after_out_valid", 32'(out_valid), 32'd0);
    check("max_sb_empty",        32'(sb_q.size()), 32'd0);

    // Backpressure and bubbles
    out_ready = 1'b0;
    sb_q.push_back(100);
    send_pair(4'd1, 4'd2, 1'b0);
    @(negedge clk);
    send_pair(4'd3, 4'd4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    send_pair(4'd5, 4'd6, 1'b0);
    send_pair(4'd7, 4'd8, 1'b0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_acc",       32'(acc),       32'd100);
      in_valid = 1'b1;
      in_last  = c[0];
      x        = 4'(c + 9);
      y        = 4'(15 - c);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Asynchronous reset mid-operation
    send_pair(4'd4, 4'd4, 1'b0);
    send_pair(4'd4, 4'd4, 1'b0);
    check("pre_reset_acc", 32'(acc), 32'd16);
    #1 rst = 1'b1;
    #1;
    check("async_rst_acc",       32'(acc),       32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb_q.push_back(64);
    for (int i = 0; i < 4; i++) send_pair(4'd4, 4'd4, 1'b0);
    wait_drain();

    // N_TERMS=16: sixteen (15,15) pairs
    for (int i = 0; i < 16; i++) begin
      b_in_valid = 1'b1;
      b_x = 4'd15;
      b_y = 4'd15;
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    check("n16_drain_in_ready",  32'(b_in_ready),  32'd0);
    check("n16_drain_out_valid", 32'(b_out_valid), 32'd0);
    @(negedge clk);
    check("n16_out_valid", 32'(b_out_valid), 32'd1);
    check("n16_acc",       32'(b_acc),       32'd3600);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("n16_after_in_ready", 32'(b_in_ready), 32'd1);
    check("n16_after_acc",      32'(b_acc),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_array_mult4_mac
